mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  AW, 32, address width
  DW, 32, data width
  MEM_LAT, 2, memory access cycles per transaction (>=1; 0 illegal)
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk  input  1  single clock, rising edge
  reset  input  1  synchronous, active-high reset
  req  input  2  per-port request level; bit0 = CPU (PORT_CPU), bit1 = loader/debug (PORT_LDR)
  we  input  2  per-port write enable, qualified by req
  addr  input  2*AW  packed addresses; port n at [n*AW +: AW]
  wdata  input  2*DW  packed write data; port n at [n*DW +: DW]
  ack  output  2  one-cycle per-port completion pulse
  rdata  output  DW  read data, valid in ack cycle, held until next read ack
  mem_read  output  1  memory read strobe
  mem_write  output  1  memory write strobe
  mem_addr  output  AW  memory address
  mem_wdata  output  DW  memory write data
  mem_rdata  input  DW  memory read data
  busy  output  1  high while a transaction is in progress
REQ-003 Clock and reset SHALL be one clock, reset synchronous and active-high, ports named clk and reset.

Function
REQ-004 FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-005 In IDLE with any req bit set, the arbiter SHALL grant one port at the clock edge, latch its addr/wdata/we, and enter ACCESS; with req=0 it SHALL stay in IDLE.
REQ-006 ACCESS SHALL last exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1; then DONE.
REQ-007 During ACCESS, mem_addr/mem_wdata SHALL drive the latched values; mem_read = ~latched we, mem_write = latched we; both strobes SHALL be 0 outside ACCESS.
REQ-008 On a read, rdata SHALL capture mem_rdata on the edge ending the last ACCESS cycle.
REQ-009 DONE SHALL last one cycle, with ack[granted]=1 and the other ack bit 0; DONE SHALL always return to IDLE.
REQ-010 Request-to-ack latency SHALL be MEM_LAT+1 cycles from the IDLE cycle sampling req.
REQ-011 Requesters SHALL hold req/addr/wdata/we stable until ack and drop req on the edge ending the ack cycle; the IDLE cycle after DONE therefore sees the next request.
REQ-012 If req drops mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-013 Requests arriving during ACCESS/DONE SHALL wait; none SHALL be lost while req is held.
REQ-014 On a write ack, rdata SHALL be unchanged.
REQ-015 busy SHALL be 1 in ACCESS and DONE, 0 in IDLE.

Reset
REQ-016 While reset=1 at an edge: state=IDLE, counter=0, ack=0, rdata=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, busy=0, last-grant pointer=PORT_LDR.
REQ-017 Reset mid-transaction SHALL abort it with no ack; the requester SHALL re-request.

Configuration
REQ-018 With MEM_ARBITER_RR_EN defined, simultaneous requests SHALL go to the port not granted last, and the pointer SHALL update on every grant; a lone request SHALL be granted regardless of the pointer.
REQ-019 Without MEM_ARBITER_RR_EN, PORT_CPU SHALL always win simultaneous requests, and no pointer register SHALL exist.

Structure
REQ-020 Package mem_arbiter_pkg SHALL hold the state enum (IDLE, ACCESS, DONE) and the constants PORT_CPU=0 and PORT_LDR=1.
REQ-021 Grant selection SHALL be the combinational sub-module arb_select (inputs: req, last-grant pointer; output: grant index), with the RR/fixed choice inside it.

Verification (MEM_LAT=2)
REQ-022 CPU read of addr 0x40 with mem_rdata=0xDEADBEEF: mem_read high for 2 cycles, ack=2'b01 on the 3rd cycle, rdata=0xDEADBEEF.
REQ-023 Loader write of 0x1234 to 0x80: mem_write high for 2 cycles with mem_addr=0x80 and mem_wdata=0x1234, then ack=2'b10; rdata unchanged.
REQ-024 Both ports request continuously for 4 transactions: with RR_EN, grants go CPU, LDR, CPU, LDR; without RR_EN, every grant goes to CPU until its req drops.
REQ-025 Reset asserted in the 2nd ACCESS cycle: strobes are 0 next cycle, no ack, state IDLE, and a fresh request completes normally.
REQ-026 Loader requests during a CPU ACCESS: the loader is granted in the IDLE cycle after the CPU ack, and its ack arrives 3 cycles later.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and port indices.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // One-hot ack pattern for a granted port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Grant selection between CPU and loader ports; round-robin when MEM_ARBITER_RR_EN is defined, else CPU-fixed priority.
// Latency: purely combinational.
// Backpressure: none; the caller only consults grant while req is non-zero.
module arb_select
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

`ifdef MEM_ARBITER_RR_EN
    // A lone request wins outright; a tie goes to the port not served last.
    always_comb begin
        grant = PORT_CPU;
        case (req)
            2'b01:   grant = PORT_CPU;
            2'b10:   grant = PORT_LDR;
            2'b11:   grant = ~last;
            default: grant = PORT_CPU;
        endcase
    end
`else
    // The last-grant input has no meaning under fixed priority.
    logic unused_last;
    assign unused_last = last;

    // CPU always wins whenever it is requesting.
    always_comb begin
        grant = PORT_CPU;
        if (!req[0] && req[1]) begin
            grant = PORT_LDR;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) memory arbiter with IDLE -> ACCESS (MEM_LAT cycles) -> DONE sequencing; optional round-robin via MEM_ARBITER_RR_EN.
// Latency: ack pulses MEM_LAT+1 cycles after the IDLE cycle that samples req.
// Backpressure: requesters hold req/addr/wdata/we until ack; requests arriving while busy simply wait.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic            mem_read,
    output logic            mem_write,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    // Counter wide enough to hold MEM_LAT-1; at least one bit.
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            gnt;
    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [DW-1:0]   rdata_q;
    logic            last_gnt;
    logic            sel;
    logic            take;

    // A grant happens only from IDLE with at least one request pending.
    assign take = (state == IDLE) && (req != 2'b00);

`ifdef MEM_ARBITER_RR_EN
    // Remember who was served last so ties alternate.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= PORT_LDR;
        end else if (take) begin
            last_gnt <= sel;
        end
    end
`else
    // Fixed priority keeps no history; the selector ignores this value.
    assign last_gnt = PORT_LDR;
`endif

    arb_select u_arb_select (
        .req   (req),
        .last  (last_gnt),
        .grant (sel)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; strobes and ack are pure functions of state.
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ack       = 2'b00;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_read  = ~lat_we;
                mem_write = lat_we;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                ack       = port_onehot(gnt);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transaction latch, access down-counter and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            gnt       <= PORT_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else if (take) begin
            cnt       <= CW'(MEM_LAT - 1);
            gnt       <= sel;
            lat_we    <= sel ? we[1] : we[0];
            lat_addr  <= sel ? addr[AW +: AW] : addr[0 +: AW];
            lat_wdata <= sel ? wdata[DW +: DW] : wdata[0 +: DW];
        end else if (state == ACCESS) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else if (!lat_we) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized requesters against a timeline model.
// Latency: model predicts ack at grant cycle + MEM_LAT + 1.
// Backpressure: requester agents hold their request until ack, occasionally dropping it mid-transaction.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            mem_read;
    logic            mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: a transaction is just (start cycle, port, we, addr, wdata).
    int            cyc;
    bit            m_busy;
    int            m_start;
    bit            m_port;
    bit            m_we;
    bit            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    int n_cmp;
    int n_err;
    bit [1:0] outst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        int       d;
        bit [1:0] e_ack;
        bit       e_rd;
        bit       e_wr;
        bit       e_busy;
        e_ack  = 2'b00;
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        e_busy = 1'b0;
        if (m_busy) begin
            d      = cyc - m_start;
            e_busy = 1'b1;
            if (d >= 1 && d <= LAT) begin
                e_rd = ~m_we;
                e_wr = m_we;
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end else if (d == LAT + 1) begin
                e_ack = m_port ? 2'b10 : 2'b01;
            end
        end
        chk("ack", 64'(ack), 64'(e_ack));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("mem_read", 64'(mem_read), 64'(e_rd));
        chk("mem_write", 64'(mem_write), 64'(e_wr));
        chk("rdata", 64'(rdata), 64'(m_rdata));
    endtask

    // Advance the model across the edge that ends the current cycle.
    task automatic model_update();
        int d;
        bit p;
        if (reset) begin
            m_busy  = 1'b0;
            m_rdata = '0;
            m_last  = 1'b1;
            m_addr  = '0;
            m_wdata = '0;
        end else if (m_busy) begin
            d = cyc - m_start;
            if (d == LAT && !m_we) m_rdata = mem_rdata;
            if (d == LAT + 1) m_busy = 1'b0;
        end else if (req != 2'b00) begin
            if (req == 2'b01)      p = 1'b0;
            else if (req == 2'b10) p = 1'b1;
            else                   p = RR ? ~m_last : 1'b0;
            m_busy  = 1'b1;
            m_start = cyc;
            m_port  = p;
            m_we    = we[p];
            m_addr  = p ? addr[AW +: AW] : addr[0 +: AW];
            m_wdata = p ? wdata[DW +: DW] : wdata[0 +: DW];
            m_last  = p;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_err     = 0;
        outst     = 2'b00;
        m_busy    = 1'b0;
        m_start   = 0;
        m_port    = 1'b0;
        m_we      = 1'b0;
        m_last    = 1'b1;
        m_addr    = '0;
        m_wdata   = '0;
        m_rdata   = '0;
        reset     = 1'b1;
        req       = 2'b00;
        we        = 2'b00;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;

        // Reset state.
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        step();

        // CPU read of 0x40 returning 0xDEADBEEF.
        req = 2'b01; we = 2'b00; addr[31:0] = 32'h40; mem_rdata = 32'hDEADBEEF;
        step();
        chk("rd_acc1_read", 64'(mem_read), 64'd1);
        chk("rd_acc1_addr", 64'(mem_addr), 64'h40);
        step();
        chk("rd_acc2_read", 64'(mem_read), 64'd1);
        step();
        chk("rd_ack", 64'(ack), 64'b01);
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("rd_done_read", 64'(mem_read), 64'd0);
        req = 2'b00; mem_rdata = 32'h0BADF00D;
        step();

        // Loader write of 0x1234 to 0x80.
        req = 2'b10; we = 2'b10; addr[63:32] = 32'h80; wdata[63:32] = 32'h1234;
        step();
        chk("wr_acc1_write", 64'(mem_write), 64'd1);
        chk("wr_acc1_addr", 64'(mem_addr), 64'h80);
        chk("wr_acc1_wdata", 64'(mem_wdata), 64'h1234);
        step();
        chk("wr_acc2_write", 64'(mem_write), 64'd1);
        step();
        chk("wr_ack", 64'(ack), 64'b10);
        chk("wr_rdata_kept", 64'(rdata), 64'hDEADBEEF);
        req = 2'b00;
        step();

        // Both ports requesting continuously for four transactions.
        req = 2'b11; we = 2'b00; addr[31:0] = 32'h100; addr[63:32] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            step();
            chk("both_ack", 64'(ack), (RR && (k % 2 == 1)) ? 64'b10 : 64'b01);
            step();
        end
        req = 2'b00;
        step();

        // Reset during the second ACCESS cycle, then a fresh request.
        req = 2'b01; we = 2'b00; addr[31:0] = 32'h44; mem_rdata = 32'h55AA55AA;
        step();
        step();
        chk("rst_mid_in_access", 64'(mem_read), 64'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_read", 64'(mem_read), 64'd0);
        chk("rst_mid_ack", 64'(ack), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();
        step();
        step();
        chk("rst_retry_ack", 64'(ack), 64'b01);
        chk("rst_retry_rdata", 64'(rdata), 64'h55AA55AA);
        req = 2'b00;
        step();

        // Loader arrives while the CPU is in ACCESS.
        req = 2'b01; we = 2'b00; addr[31:0] = 32'h48;
        step();
        req = 2'b11; addr[63:32] = 32'h88;
        step();
        step();
        chk("late_cpu_ack", 64'(ack), 64'b01);
        req = 2'b10;
        step();
        chk("late_idle_busy", 64'(busy), 64'd0);
        step();
        step();
        step();
        chk("late_ldr_ack", 64'(ack), 64'b10);
        req = 2'b00;
        step();

        // Randomized requesters.
        for (int i = 0; i < 4000; i++) begin
            if (reset) reset = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (ack[n]) begin
                    outst[n] = 1'b0;
                    req[n]   = 1'b0;
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                outst = 2'b00;
                req   = 2'b00;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (!outst[n] && $urandom_range(0, 2) == 0) begin
                        outst[n]           = 1'b1;
                        req[n]             = 1'b1;
                        we[n]              = 1'($urandom_range(0, 1));
                        addr[n*AW +: AW]   = $urandom;
                        wdata[n*DW +: DW]  = $urandom;
                    end else if (outst[n] && req[n] && m_busy && (int'(m_port) == n)
                                 && $urandom_range(0, 29) == 0) begin
                        req[n] = 1'b0;
                    end
                end
            end
            mem_rdata = $urandom;
            step();
        end

        reset = 1'b0;
        req   = 2'b00;
        for (int i = 0; i < 6; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
